// File: rtl/i2c_txn_sequencer_if.sv
// Bundle of the request, write-stream, read-stream, byte-engine and status
// signals around the I2C transaction sequencer.
interface i2c_txn_sequencer_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_op;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  req_rstart;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdata_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic [1:0]            rsp_code;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;

  // master: host plus byte engine driving the sequencer
  modport master (
    output req_valid, req_addr, req_op, req_len, req_rstart,
    output wdata_valid, wdata, cmd_ready, rsp_valid, rsp_code, rsp_data,
    input  req_ready, wdata_ready, rdata_valid, rdata, cmd_valid, cmd, cmd_data,
    input  busy, done, err, err_code
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_len, req_rstart,
    input  wdata_valid, wdata, cmd_ready, rsp_valid, rsp_code, rsp_data,
    output req_ready, wdata_ready, rdata_valid, rdata, cmd_valid, cmd, cmd_data,
    output busy, done, err, err_code
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Sequences one I2C transaction (START, address, data bytes, STOP) as a series
// of commands to a byte-level engine, one command outstanding at a time.
module i2c_txn_sequencer #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_op_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic                  req_rstart_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_o,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  input  logic                  rsp_valid_i,
  input  logic [1:0]            rsp_code_i,
  input  logic [DATA_WIDTH-1:0] rsp_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);
  localparam logic [2:0] CMD_START = 3'd0, CMD_STOP = 3'd1, CMD_WRITE = 3'd2,
                         CMD_RACK  = 3'd3, CMD_RNAK = 3'd4;
  localparam logic [1:0] RSP_DONE = 2'd0, RSP_ACK = 2'd1, RSP_NAK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WDATA, S_WRITE, S_READ, S_STOP, S_WAIT
  } state_t;

  state_t                r_state, r_from;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_op, r_rstart, r_req_ready;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_wbyte, r_rdata, r_cmd_data;
  logic [1:0]            r_abort, r_err_code;
  logic                  r_cmd_valid, r_rdata_valid, r_done, r_err;
  logic [2:0]            r_cmd;

  logic [2:0]            w_cmd;
  logic [DATA_WIDTH-1:0] w_cmd_data;
  logic                  w_rsp_ok, w_last;
  state_t                w_fin_state;

  always_comb begin
    w_cmd      = CMD_START;
    w_cmd_data = '0;
    case (r_state)
      S_STOP:  w_cmd = CMD_STOP;
      S_ADDR:  begin w_cmd = CMD_WRITE; w_cmd_data = DATA_WIDTH'({r_addr, r_op}); end
      S_WRITE: begin w_cmd = CMD_WRITE; w_cmd_data = r_wbyte; end
      S_READ:  w_cmd = (r_cnt > LEN_WIDTH'(1)) ? CMD_RACK : CMD_RNAK;
      default: w_cmd = CMD_START;
    endcase
  end

  // Anything a given command cannot legally return (incl. ARB_LOST) is arbitration loss.
  always_comb begin
    case (r_from)
      S_ADDR, S_WRITE: w_rsp_ok = (rsp_code_i == RSP_ACK) || (rsp_code_i == RSP_NAK);
      default:         w_rsp_ok = (rsp_code_i == RSP_DONE);
    endcase
  end

  assign w_last      = (r_cnt == LEN_WIDTH'(1));
  assign w_fin_state = r_rstart ? S_IDLE : S_STOP;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= S_IDLE;
      r_from        <= S_IDLE;
      r_addr        <= '0;
      r_op          <= 1'b0;
      r_rstart      <= 1'b0;
      r_req_ready   <= 1'b0;
      r_cnt         <= '0;
      r_wbyte       <= '0;
      r_rdata       <= '0;
      r_cmd_data    <= '0;
      r_cmd         <= '0;
      r_abort       <= '0;
      r_err_code    <= '0;
      r_cmd_valid   <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rdata_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_addr      <= req_addr_i;
            r_op        <= req_op_i;
            r_cnt       <= req_len_i;
            r_rstart    <= req_rstart_i;
            r_abort     <= '0;
            r_req_ready <= 1'b0;
            r_state     <= S_START;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_START, S_ADDR, S_WRITE, S_READ, S_STOP: begin
          if (!r_cmd_valid) begin
            r_cmd_valid <= 1'b1;
            r_cmd       <= w_cmd;
            r_cmd_data  <= w_cmd_data;
          end else if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
            r_from      <= r_state;
            r_state     <= S_WAIT;
          end
        end
        S_WDATA: begin
          if (wdata_valid_i) begin
            r_wbyte <= wdata_i;
            r_state <= S_WRITE;
          end
        end
        S_WAIT: begin
          if (rsp_valid_i) begin
            if (!w_rsp_ok) begin
              r_err       <= 1'b1;
              r_err_code  <= 2'd3;
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              case (r_from)
                S_START: r_state <= S_ADDR;
                S_ADDR: begin
                  if (rsp_code_i == RSP_NAK) begin
                    r_abort <= 2'd1;
                    r_state <= S_STOP;
                  end else if (r_cnt == '0) begin
                    r_state     <= w_fin_state;
                    r_done      <= r_rstart;
                    r_req_ready <= r_rstart;
                  end else begin
                    r_state <= r_op ? S_READ : S_WDATA;
                  end
                end
                S_WRITE: begin
                  if (rsp_code_i == RSP_NAK) begin
                    r_abort <= 2'd2;
                    r_state <= S_STOP;
                  end else begin
                    r_cnt <= r_cnt - LEN_WIDTH'(1);
                    if (w_last) begin
                      r_state     <= w_fin_state;
                      r_done      <= r_rstart;
                      r_req_ready <= r_rstart;
                    end else begin
                      r_state <= S_WDATA;
                    end
                  end
                end
                S_READ: begin
                  r_rdata_valid <= 1'b1;
                  r_rdata       <= rsp_data_i;
                  r_cnt         <= r_cnt - LEN_WIDTH'(1);
                  if (w_last) begin
                    r_state     <= w_fin_state;
                    r_done      <= r_rstart;
                    r_req_ready <= r_rstart;
                  end else begin
                    r_state <= S_READ;
                  end
                end
                default: begin
                  // STOP completed: report whichever outcome was pending
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
                  if (r_abort != 2'd0) begin
                    r_err      <= 1'b1;
                    r_err_code <= r_abort;
                  end else begin
                    r_done <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o   = r_req_ready;
  assign wdata_ready_o = (r_state == S_WDATA);
  assign busy_o        = (r_state != S_IDLE);
  assign cmd_valid_o   = r_cmd_valid;
  assign cmd_o         = r_cmd;
  assign cmd_data_o    = r_cmd_data;
  assign rdata_valid_o = r_rdata_valid;
  assign rdata_o       = r_rdata;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign err_code_o    = r_err_code;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: a scripted byte-engine model answers
// commands, and each transaction's command log and status are checked.
module tb_i2c_txn_sequencer;
  localparam int AW = 7, DW = 8, LW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  i2c_txn_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (bus.req_valid),
    .req_ready_o  (bus.req_ready),
    .req_addr_i   (bus.req_addr),
    .req_op_i     (bus.req_op),
    .req_len_i    (bus.req_len),
    .req_rstart_i (bus.req_rstart),
    .wdata_valid_i(bus.wdata_valid),
    .wdata_ready_o(bus.wdata_ready),
    .wdata_i      (bus.wdata),
    .rdata_valid_o(bus.rdata_valid),
    .rdata_o      (bus.rdata),
    .cmd_valid_o  (bus.cmd_valid),
    .cmd_ready_i  (bus.cmd_ready),
    .cmd_o        (bus.cmd),
    .cmd_data_o   (bus.cmd_data),
    .rsp_valid_i  (bus.rsp_valid),
    .rsp_code_i   (bus.rsp_code),
    .rsp_data_i   (bus.rsp_data),
    .busy_o       (bus.busy),
    .done_o       (bus.done),
    .err_o        (bus.err),
    .err_code_o   (bus.err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine-side knobs and data, written only by the main process
  int         nak_wr_n    = 0;  // n-th WRITE (address byte = 1) answers NAK
  int         hold_wr_n   = 0;  // n-th WRITE is never accepted
  bit         arb_on_read = 1'b0;
  logic [7:0] wbytes [8];
  logic [7:0] rd_src [8];

  // Observations, written only by the engine/monitor process
  logic [11:0] log_q [$];       // {0, cmd, data-for-WRITE}
  logic [7:0]  rd_seen [$];
  int          wr_count = 0, wd_idx = 0, rd_idx = 0, wd_acc = 0;
  int          done_cnt = 0, err_cnt = 0, both_cnt = 0, wrdy_seen = 0;
  logic [1:0]  last_code = 2'd0;
  bit          wd_adv = 1'b0, pending = 1'b0;
  logic [1:0]  pend_code = 2'd0;
  logic [7:0]  pend_data = 8'h00;

  initial begin
    bus.cmd_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_code  = 2'd0;
    bus.rsp_data  = 8'h00;
    bus.wdata     = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.err) begin
        err_cnt++;
        last_code = bus.err_code;
      end
      if (bus.done && bus.err) both_cnt++;
      if (bus.rdata_valid) rd_seen.push_back(bus.rdata);
      if (bus.wdata_ready) wrdy_seen++;
      if (wd_adv) begin
        wd_idx++;
        wd_adv = 1'b0;
      end
      bus.wdata = wbytes[wd_idx % 8];
      if (bus.wdata_valid && bus.wdata_ready) begin
        wd_acc++;
        wd_adv = 1'b1;
      end
      bus.rsp_valid = 1'b0;
      if (pending) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_code  = pend_code;
        bus.rsp_data  = pend_data;
        pending       = 1'b0;
      end else begin
        bus.cmd_ready = !(bus.cmd_valid && bus.cmd == 3'd2 && hold_wr_n == wr_count + 1);
        if (bus.cmd_valid && bus.cmd_ready) begin
          log_q.push_back({1'b0, bus.cmd, (bus.cmd == 3'd2) ? bus.cmd_data : 8'h00});
          pend_code = 2'd0;
          pend_data = 8'h00;
          case (bus.cmd)
            3'd0: wr_count = 0;
            3'd2: begin
              wr_count++;
              pend_code = (wr_count == nak_wr_n) ? 2'd2 : 2'd1;
            end
            3'd3, 3'd4: begin
              pend_code = arb_on_read ? 2'd3 : 2'd0;
              pend_data = rd_src[rd_idx % 8];
              rd_idx++;
            end
            default: pend_code = 2'd0;
          endcase
          pending = 1'b1;
        end
      end
    end
  end

  // Per-test baselines so the main process never writes the monitor's state
  int          b_log, b_rd, b_done, b_err, b_wacc, b_wrdy;
  logic [11:0] exp_q [$];

  task automatic mark();
    b_log  = log_q.size();
    b_rd   = rd_seen.size();
    b_done = done_cnt;
    b_err  = err_cnt;
    b_wacc = wd_acc;
    b_wrdy = wrdy_seen;
  endtask

  task automatic set_wb(input int k, input logic [7:0] v);
    wbytes[(wd_idx + k) % 8] = v;
  endtask

  task automatic set_rd(input int k, input logic [7:0] v);
    rd_src[(rd_idx + k) % 8] = v;
  endtask

  task automatic send_req(input string tag, input logic [6:0] addr, input logic op,
                          input logic [4:0] len, input logic rstart);
    logic got;
    got = 1'b0;
    @(negedge clk);
    bus.req_addr   = addr;
    bus.req_op     = op;
    bus.req_len    = len;
    bus.req_rstart = rstart;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk_eq({tag, "_accept"}, 32'(got), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int n_end);
    for (int i = 0; i < 1000; i++) begin
      if ((done_cnt - b_done) + (err_cnt - b_err) >= n_end) break;
      @(negedge clk);
    end
    chk_eq({tag, "_ended"}, 32'((done_cnt - b_done) + (err_cnt - b_err) >= n_end), 32'd1);
    repeat (3) @(negedge clk);
    $display("txn %s: cmds=%0d done=%0d err=%0d code=%0d", tag, log_q.size() - b_log,
             done_cnt - b_done, err_cnt - b_err, last_code);
  endtask

  task automatic chk_log(input string tag);
    logic [11:0] got;
    chk_eq({tag, "_ncmd"}, 32'(log_q.size() - b_log), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (b_log + k < log_q.size()) ? log_q[b_log + k] : 12'hFFF;
      chk_eq($sformatf("%s_cmd%0d", tag, k), 32'(got), 32'(exp_q[k]));
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_op      = 1'b0;
    bus.req_len     = '0;
    bus.req_rstart  = 1'b0;
    bus.wdata_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wbytes[i] = 8'h00;
      rd_src[i] = 8'h00;
    end

    // Reset values while held in reset, then ready after release
    repeat (3) @(negedge clk);
    chk_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk_eq("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    chk_eq("rst_done_err", 32'({bus.done, bus.err, bus.rdata_valid}), 32'd0);
    chk_eq("rst_err_code", 32'(bus.err_code), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk_eq("idle_busy", 32'(bus.busy), 32'd0);

    // Write 0x50, two bytes, all ACK
    mark();
    set_wb(0, 8'hA5);
    set_wb(1, 8'h3C);
    bus.wdata_valid = 1'b1;
    send_req("wr2", 7'h50, 1'b0, 5'd2, 1'b0);
    wait_end("wr2", 1);
    exp_q = '{12'h000, 12'h2A0, 12'h2A5, 12'h23C, 12'h100};
    chk_log("wr2");
    chk_eq("wr2_done", 32'(done_cnt - b_done), 32'd1);
    chk_eq("wr2_err", 32'(err_cnt - b_err), 32'd0);
    chk_eq("wr2_wacc", 32'(wd_acc - b_wacc), 32'd2);
    chk_eq("wr2_busy", 32'(bus.busy), 32'd0);

    // Read 0x27, three bytes
    mark();
    bus.wdata_valid = 1'b0;
    set_rd(0, 8'h11);
    set_rd(1, 8'h22);
    set_rd(2, 8'h33);
    send_req("rd3", 7'h27, 1'b1, 5'd3, 1'b0);
    wait_end("rd3", 1);
    exp_q = '{12'h000, 12'h24F, 12'h300, 12'h300, 12'h400, 12'h100};
    chk_log("rd3");
    chk_eq("rd3_nrdata", 32'(rd_seen.size() - b_rd), 32'd3);
    chk_eq("rd3_rdata0", 32'((rd_seen.size() > b_rd) ? rd_seen[b_rd] : 8'h00), 32'h11);
    chk_eq("rd3_rdata1", 32'((rd_seen.size() > b_rd + 1) ? rd_seen[b_rd + 1] : 8'h00), 32'h22);
    chk_eq("rd3_rdata2", 32'((rd_seen.size() > b_rd + 2) ? rd_seen[b_rd + 2] : 8'h00), 32'h33);
    chk_eq("rd3_done", 32'(done_cnt - b_done), 32'd1);

    // Address NAK aborts with STOP and code 1
    mark();
    nak_wr_n = 1;
    bus.wdata_valid = 1'b1;
    send_req("anak", 7'h50, 1'b0, 5'd2, 1'b0);
    wait_end("anak", 1);
    exp_q = '{12'h000, 12'h2A0, 12'h100};
    chk_log("anak");
    chk_eq("anak_err", 32'(err_cnt - b_err), 32'd1);
    chk_eq("anak_code", 32'(last_code), 32'd1);
    chk_eq("anak_code_held", 32'(bus.err_code), 32'd1);
    chk_eq("anak_done", 32'(done_cnt - b_done), 32'd0);
    chk_eq("anak_wrdy", 32'(wrdy_seen - b_wrdy), 32'd0);
    nak_wr_n = 0;

    // Data NAK on second byte of three
    mark();
    nak_wr_n = 3;
    set_wb(0, 8'h01);
    set_wb(1, 8'h02);
    set_wb(2, 8'h03);
    send_req("dnak", 7'h50, 1'b0, 5'd3, 1'b0);
    wait_end("dnak", 1);
    exp_q = '{12'h000, 12'h2A0, 12'h201, 12'h202, 12'h100};
    chk_log("dnak");
    chk_eq("dnak_code", 32'(last_code), 32'd2);
    chk_eq("dnak_wacc", 32'(wd_acc - b_wacc), 32'd2);
    chk_eq("dnak_done", 32'(done_cnt - b_done), 32'd0);
    nak_wr_n = 0;

    // Write with repeated start, then read the same address
    mark();
    set_wb(0, 8'h77);
    set_rd(0, 8'h99);
    send_req("rs_wr", 7'h50, 1'b0, 5'd1, 1'b1);
    wait_end("rs_wr", 1);
    chk_eq("rs_wr_nostop", 32'(log_q.size() - b_log), 32'd3);
    send_req("rs_rd", 7'h50, 1'b1, 5'd1, 1'b0);
    wait_end("rs_rd", 2);
    exp_q = '{12'h000, 12'h2A0, 12'h277, 12'h000, 12'h2A1, 12'h400, 12'h100};
    chk_log("rs");
    chk_eq("rs_done", 32'(done_cnt - b_done), 32'd2);
    chk_eq("rs_rdata", 32'((rd_seen.size() > b_rd) ? rd_seen[b_rd] : 8'h00), 32'h99);

    // Arbitration lost during a read: no STOP, code 3
    mark();
    arb_on_read = 1'b1;
    set_rd(0, 8'h44);
    send_req("arb", 7'h27, 1'b1, 5'd2, 1'b0);
    wait_end("arb", 1);
    exp_q = '{12'h000, 12'h24F, 12'h300};
    chk_log("arb");
    chk_eq("arb_err", 32'(err_cnt - b_err), 32'd1);
    chk_eq("arb_code", 32'(last_code), 32'd3);
    chk_eq("arb_done", 32'(done_cnt - b_done), 32'd0);
    chk_eq("arb_busy", 32'(bus.busy), 32'd0);
    arb_on_read = 1'b0;

    // Reset mid-WRITE while the data command is stalled
    mark();
    hold_wr_n = 2;
    set_wb(0, 8'h5A);
    send_req("rstw", 7'h50, 1'b0, 5'd1, 1'b0);
    repeat (20) @(negedge clk);
    chk_eq("rstw_stall_valid", 32'(bus.cmd_valid), 32'd1);
    chk_eq("rstw_stall_data", 32'(bus.cmd_data), 32'h5A);
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("rstw_busy", 32'(bus.busy), 32'd0);
    chk_eq("rstw_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk_eq("rstw_err_code", 32'(bus.err_code), 32'd0);
    hold_wr_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("txn rstw: cmds=%0d done=%0d err=%0d", log_q.size() - b_log,
             done_cnt - b_done, err_cnt - b_err);
    exp_q = '{12'h000, 12'h2A0};
    chk_log("rstw");
    chk_eq("rstw_done_err", 32'((done_cnt - b_done) + (err_cnt - b_err)), 32'd0);

    // Zero-length address probe
    mark();
    send_req("probe", 7'h50, 1'b0, 5'd0, 1'b0);
    wait_end("probe", 1);
    exp_q = '{12'h000, 12'h2A0, 12'h100};
    chk_log("probe");
    chk_eq("probe_done", 32'(done_cnt - b_done), 32'd1);
    chk_eq("probe_wrdy", 32'(wrdy_seen - b_wrdy), 32'd0);

    chk_eq("done_err_overlap", 32'(both_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
